// File: rtl/beat_sequencer_clock.sv
// Beat clock for the step sequencer: divides clk into 8 beats per measure at an
// adjustable tempo and debounces the tempo buttons into single-step changes.
module beat_sequencer_clock #(
  parameter int BASE_TICKS    = 5000,
  parameter int STEP_TICKS    = 500,
  parameter int DEFAULT_TEMPO = 4,
  parameter int CNT_W         = 13
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sequencer_on,
  input  logic       tempo_up,
  input  logic       tempo_down,
  output logic [2:0] beat,
  output logic       beat_strobe,
  output logic [2:0] tempo_idx,
  output logic       state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] BASE_C  = CNT_W'(BASE_TICKS);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP_TICKS);
  localparam logic [2:0]       TEMPO_R = 3'(DEFAULT_TEMPO);

  logic [1:0]       up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
  logic             up_prev_q, up_prev_d, dn_prev_q, dn_prev_d;
  logic             up_edge, dn_edge;
  logic [2:0]       tempo_idx_q, tempo_idx_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] period, period_m1;
  logic [2:0]       beat_q, beat_d;
  logic             beat_strobe_q, beat_strobe_d;
  logic [0:0]       state_q, state_cur;

  // Buttons are asynchronous: two sync stages, then a previous-value stage for edges.
  always_comb begin
    up_sync_d = {up_sync_q[0], tempo_up};
    dn_sync_d = {dn_sync_q[0], tempo_down};
    up_prev_d = up_sync_q[1];
    dn_prev_d = dn_sync_q[1];
    up_edge   = up_sync_q[1] & ~up_prev_q;
    dn_edge   = dn_sync_q[1] & ~dn_prev_q;
  end

  always_comb begin
    tempo_idx_d = tempo_idx_q;
    case ({up_edge, dn_edge})
      2'b10:   if (tempo_idx_q != 3'd7) tempo_idx_d = tempo_idx_q + 3'd1;
      2'b01:   if (tempo_idx_q != 3'd0) tempo_idx_d = tempo_idx_q - 3'd1;
      default: tempo_idx_d = tempo_idx_q;
    endcase
  end

  // >= rather than == so a tempo increase that shortens the period ends the beat at once.
  always_comb begin
    period        = BASE_C - STEP_C * CNT_W'(tempo_idx_q);
    period_m1     = period - CNT_W'(1);
    state_cur     = sequencer_on ? RUN : IDLE;
    tick_cnt_d    = '0;
    beat_d        = 3'd0;
    beat_strobe_d = 1'b0;
    if (state_cur == RUN) begin
      if (tick_cnt_q >= period_m1) begin
        tick_cnt_d    = '0;
        beat_d        = beat_q + 3'd1;
        beat_strobe_d = 1'b1;
      end else begin
        tick_cnt_d    = tick_cnt_q + CNT_W'(1);
        beat_d        = beat_q;
        beat_strobe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      up_sync_q     <= 2'b00;
      dn_sync_q     <= 2'b00;
      up_prev_q     <= 1'b0;
      dn_prev_q     <= 1'b0;
      tempo_idx_q   <= TEMPO_R;
      tick_cnt_q    <= '0;
      beat_q        <= 3'd0;
      beat_strobe_q <= 1'b0;
      state_q       <= IDLE;
    end else begin
      up_sync_q     <= up_sync_d;
      dn_sync_q     <= dn_sync_d;
      up_prev_q     <= up_prev_d;
      dn_prev_q     <= dn_prev_d;
      tempo_idx_q   <= tempo_idx_d;
      tick_cnt_q    <= tick_cnt_d;
      beat_q        <= beat_d;
      beat_strobe_q <= beat_strobe_d;
      state_q       <= state_cur;
    end
  end

  assign beat        = beat_q;
  assign beat_strobe = beat_strobe_q;
  assign tempo_idx   = tempo_idx_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_beat_sequencer_clock.sv
// Bench for beat_sequencer_clock: directed vector table, corner-case sequences and
// randomized traffic, all checked against a cycle-by-cycle reference model.
module tb_beat_sequencer_clock;

  localparam int BASE = 20;
  localparam int STEP = 2;
  localparam int DEF  = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       sequencer_on = 1'b0;
  logic       tempo_up = 1'b0;
  logic       tempo_down = 1'b0;
  logic [2:0] beat;
  logic       beat_strobe;
  logic [2:0] tempo_idx;
  logic       state_dbg;

  beat_sequencer_clock #(
    .BASE_TICKS(BASE), .STEP_TICKS(STEP), .DEFAULT_TEMPO(DEF), .CNT_W(13)
  ) dut (
    .clk(clk), .n_rst(n_rst), .sequencer_on(sequencer_on),
    .tempo_up(tempo_up), .tempo_down(tempo_down),
    .beat(beat), .beat_strobe(beat_strobe), .tempo_idx(tempo_idx),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int max_tick = 0;

  // reference model state
  int   m_beat, m_tick, m_tempo;
  logic m_strobe;
  logic up_h[$];
  logic dn_h[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beat = 0; m_tick = 0; m_tempo = DEF; m_strobe = 1'b0;
    up_h = '{1'b0, 1'b0, 1'b0};
    dn_h = '{1'b0, 1'b0, 1'b0};
  endtask

  // A button edge registers at edge n when the raw level sampled two edges
  // earlier was 1 and the one three edges earlier was 0.
  task automatic model_edge();
    int  p;
    bit  ue, de;
    p = BASE - STEP * m_tempo;
    up_h.push_back(tempo_up);
    dn_h.push_back(tempo_down);
    if (up_h.size() > 4) void'(up_h.pop_front());
    if (dn_h.size() > 4) void'(dn_h.pop_front());
    ue = up_h[1] && !up_h[0];
    de = dn_h[1] && !dn_h[0];
    if (sequencer_on) begin
      if (m_tick >= p - 1) begin
        m_tick = 0; m_beat = (m_beat + 1) % 8; m_strobe = 1'b1;
      end else begin
        m_tick = m_tick + 1; m_strobe = 1'b0;
      end
    end else begin
      m_tick = 0; m_beat = 0; m_strobe = 1'b0;
    end
    if (ue && !de && m_tempo < 7) m_tempo = m_tempo + 1;
    else if (de && !ue && m_tempo > 0) m_tempo = m_tempo - 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_beat", int'(beat), m_beat);
    check("model_strobe", int'(beat_strobe), int'(m_strobe));
    check("model_tempo", int'(tempo_idx), m_tempo);
    check("model_tick", int'(dut.tick_cnt_q), m_tick);
    if (int'(dut.tick_cnt_q) > max_tick) max_tick = int'(dut.tick_cnt_q);
  endtask

  task automatic press(input logic u, input logic d);
    tempo_up = u; tempo_down = d;
    step();
    tempo_up = 1'b0; tempo_down = 1'b0;
    repeat (3) step();
  endtask

  task automatic async_reset(input string name);
    n_rst = 1'b0;
    model_reset();
    #1;
    check({name, "_beat"}, int'(beat), 0);
    check({name, "_strobe"}, int'(beat_strobe), 0);
    check({name, "_tempo"}, int'(tempo_idx), DEF);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic wait_model(input int b, input int t, input string name);
    int n = 0;
    while (!((b < 0 || m_beat == b) && m_tick == t) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      n_fail++;
      n_checks++;
      $display("FAIL %s: timeout waiting for beat %0d tick %0d", name, b, t);
    end
  endtask

  typedef struct {
    logic       seq;
    logic       up;
    logic       dn;
    int         ncyc;
    logic [2:0] exp_beat;
    logic       exp_strobe;
    logic [2:0] exp_tempo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 11, 3'd0, 1'b0, 3'd4};
    vecs[1] = '{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b1, 3'd4};
    vecs[2] = '{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 3'd4};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 83, 3'd0, 1'b1, 3'd4};
    vecs[4] = '{1'b1, 1'b1, 1'b0,  2, 3'd0, 1'b0, 3'd4};
    vecs[5] = '{1'b1, 1'b1, 1'b0,  1, 3'd0, 1'b0, 3'd5};
    vecs[6] = '{1'b1, 1'b1, 1'b0,  2, 3'd0, 1'b0, 3'd5};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 10, 3'd1, 1'b0, 3'd5};
    vecs[8] = '{1'b1, 1'b0, 1'b0,  5, 3'd2, 1'b1, 3'd5};

    model_reset();
    #1;
    async_reset("reset");

    for (int i = 0; i < 9; i++) begin
      sequencer_on = vecs[i].seq;
      tempo_up     = vecs[i].up;
      tempo_down   = vecs[i].dn;
      repeat (vecs[i].ncyc) step();
      check($sformatf("vec%0d_beat", i), int'(beat), int'(vecs[i].exp_beat));
      check($sformatf("vec%0d_strobe", i), int'(beat_strobe), int'(vecs[i].exp_strobe));
      check($sformatf("vec%0d_tempo", i), int'(tempo_idx), int'(vecs[i].exp_tempo));
    end

    // saturation at both ends and simultaneous presses
    repeat (3) press(1'b1, 1'b0);
    check("sat_up_7", int'(tempo_idx), 7);
    press(1'b1, 1'b0);
    check("sat_up_hold", int'(tempo_idx), 7);
    repeat (7) press(1'b0, 1'b1);
    check("down_to_0", int'(tempo_idx), 0);
    press(1'b0, 1'b1);
    check("sat_down_hold", int'(tempo_idx), 0);
    repeat (3) press(1'b1, 1'b0);
    check("up_to_3", int'(tempo_idx), 3);
    press(1'b1, 1'b1);
    check("both_no_change", int'(tempo_idx), 3);

    // shortening the period below the running count ends the beat immediately
    repeat (3) press(1'b0, 1'b1);
    check("idx0", int'(tempo_idx), 0);
    wait_model(-1, 4, "wait_tick4");
    for (int i = 0; i < 4; i++) begin
      tempo_up = 1'b1; step();
      tempo_up = 1'b0; step();
    end
    step();
    check("overshoot_no_strobe_yet", int'(beat_strobe), 0);
    check("overshoot_tempo4", int'(tempo_idx), 4);
    check("overshoot_tick13", int'(dut.tick_cnt_q), 13);
    step();
    check("overshoot_strobe", int'(beat_strobe), 1);
    check("overshoot_tick0", int'(dut.tick_cnt_q), 0);
    check("tick_max_19", int'(max_tick <= 19), 1);

    // leaving sequencer mode mid-beat, then re-entering
    wait_model(5, 3, "wait_beat5");
    sequencer_on = 1'b0;
    step();
    check("idle_beat0", int'(beat), 0);
    check("idle_strobe0", int'(beat_strobe), 0);
    repeat (5) step();
    check("idle_hold_beat0", int'(beat), 0);
    sequencer_on = 1'b1;
    repeat (11) step();
    check("reentry_beat0", int'(beat), 0);
    check("reentry_no_strobe", int'(beat_strobe), 0);
    step();
    check("reentry_beat1", int'(beat), 1);
    check("reentry_strobe", int'(beat_strobe), 1);

    // asynchronous reset mid-beat at the fastest tempo
    repeat (3) press(1'b1, 1'b0);
    check("idx7", int'(tempo_idx), 7);
    wait_model(6, 2, "wait_beat6");
    #2;
    async_reset("midbeat_reset");
    repeat (11) step();
    check("restart_beat0", int'(beat), 0);
    step();
    check("restart_beat1", int'(beat), 1);
    check("restart_strobe", int'(beat_strobe), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) sequencer_on = ~sequencer_on;
      if ($urandom_range(0, 9) == 0) tempo_up = ~tempo_up;
      if ($urandom_range(0, 9) == 0) tempo_down = ~tempo_down;
      if (i == 1500) async_reset("rand_reset");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
